// File: rtl/riscuinho_defs.sv
// Shared RISCuinho definitions: RV32I load funct3 encodings and writeback FSM states.
package riscuinho_defs;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_LOAD_WAIT = 2'd1,
        WB_COMMIT    = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the byte/half lane, sign/zero-extends it and
// flags misaligned or reserved load encodings.
module load_align
    import riscuinho_defs::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] data,
    output logic        err
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the low address bits.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension and error classification; reserved encodings return zero.
    always_comb begin
        data = 32'h0000_0000;
        err  = 1'b0;
        case (funct3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  data = {24'h00_0000, byte_s};
            F3_LH: begin
                data = {{16{half_s[15]}}, half_s};
                err  = addr_lo[0];
            end
            F3_LHU: begin
                data = {16'h0000, half_s};
                err  = addr_lo[0];
            end
            F3_LW: begin
                data = rdata;
                err  = (addr_lo != 2'd0);
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts ALU and load results, aligns load data and drives
// the register bank write port, holding each commit until the bank is ready.
module wb_stage
    import riscuinho_defs::*;
#(
    parameter int BANK_WIDTH     = 5,
    parameter int REGISTER_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bank_ready,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [BANK_WIDTH-1:0]     ex_rd,
    input  logic                      ex_is_load,
    input  logic [2:0]                ex_funct3,
    input  logic [1:0]                ex_addr_lo,
    input  logic [REGISTER_WIDTH-1:0] ex_result,
    input  logic                      mem_rvalid,
    input  logic [REGISTER_WIDTH-1:0] mem_rdata,
    output logic                      reg_w,
    output logic [BANK_WIDTH-1:0]     rd_sel,
    output logic [REGISTER_WIDTH-1:0] rd_data,
    output logic                      fwd_valid,
    output logic [BANK_WIDTH-1:0]     fwd_rd,
    output logic [REGISTER_WIDTH-1:0] fwd_data,
    output logic                      load_err,
    output logic                      busy
);

    wb_state_t   state_r;
    logic        err_r;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] align_data_s;
    logic        align_err_s;
    logic        xfer_s;
    logic        commit_s;
    logic        writes_s;

    load_align u_load_align (
        .funct3  (funct3_r),
        .addr_lo (addr_lo_r),
        .rdata   (mem_rdata),
        .data    (align_data_s),
        .err     (align_err_s)
    );

    // Handshake and write-port qualification; everything is gated by rst.
    always_comb begin
        ex_ready  = !rst && bank_ready && (state_r == WB_IDLE || state_r == WB_COMMIT);
        xfer_s    = ex_valid && ex_ready;
        commit_s  = !rst && (state_r == WB_COMMIT);
        writes_s  = (rd_sel != {BANK_WIDTH{1'b0}}) && !err_r;
        reg_w     = commit_s && bank_ready && writes_s;
        fwd_valid = commit_s && writes_s;
        fwd_rd    = rd_sel;
        fwd_data  = rd_data;
        load_err  = commit_s && bank_ready && err_r;
        busy      = (state_r != WB_IDLE);
    end

    // FSM and latched commit contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= WB_IDLE;
            rd_sel    <= {BANK_WIDTH{1'b0}};
            rd_data   <= {REGISTER_WIDTH{1'b0}};
            err_r     <= 1'b0;
            funct3_r  <= 3'b000;
            addr_lo_r <= 2'b00;
        end else begin
            case (state_r)
                WB_IDLE, WB_COMMIT: begin
                    if (xfer_s) begin
                        rd_sel    <= ex_rd;
                        funct3_r  <= ex_funct3;
                        addr_lo_r <= ex_addr_lo;
                        err_r     <= 1'b0;
                        if (ex_is_load) begin
                            state_r <= WB_LOAD_WAIT;
                        end else begin
                            rd_data <= ex_result;
                            state_r <= WB_COMMIT;
                        end
                    end else if (state_r == WB_COMMIT && !bank_ready) begin
                        state_r <= WB_COMMIT;
                    end else begin
                        state_r <= WB_IDLE;
                    end
                end
                WB_LOAD_WAIT: begin
                    if (mem_rvalid) begin
                        rd_data <= align_data_s;
                        err_r   <= align_err_s;
                        state_r <= WB_COMMIT;
                    end else begin
                        state_r <= WB_LOAD_WAIT;
                    end
                end
                default: state_r <= WB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU and load commits, load errors, x0 writes,
// bank stalls and reset during an outstanding load.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        bank_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic [31:0] ex_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        reg_w;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_err;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    wb_stage #(.BANK_WIDTH(5), .REGISTER_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bank_ready (bank_ready),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .ex_funct3  (ex_funct3),
        .ex_addr_lo (ex_addr_lo),
        .ex_result  (ex_result),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .reg_w      (reg_w),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .load_err   (load_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one load, return data, and check the commit cycle.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] word, input logic [31:0] exp, input logic bad);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        ex_funct3 = f3; ex_addr_lo = lo;
        step();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        chk({tag, "_wait_ready"}, 32'(ex_ready), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = word;
        step();
        mem_rvalid = 1'b0;
        chk({tag, "_reg_w"}, 32'(reg_w), bad ? 32'd0 : 32'd1);
        chk({tag, "_load_err"}, 32'(load_err), bad ? 32'd1 : 32'd0);
        if (!bad) begin
            chk({tag, "_data"}, rd_data, exp);
        end else begin
            chk({tag, "_fwd"}, 32'(fwd_valid), 32'd0);
        end
        step();
        chk({tag, "_after_err"}, 32'(load_err), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; bank_ready = 1'b1; ex_valid = 1'b0; ex_rd = 5'd0;
        ex_is_load = 1'b0; ex_funct3 = 3'b000; ex_addr_lo = 2'd0;
        ex_result = 32'h0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step(); step();
        chk("rst_ex_ready", 32'(ex_ready), 32'd0);
        chk("rst_reg_w", 32'(reg_w), 32'd0);
        chk("rst_rd_sel", 32'(rd_sel), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_ex_ready", 32'(ex_ready), 32'd1);

        // ALU op
        ex_valid = 1'b1; ex_rd = 5'd5; ex_result = 32'hDEAD_BEEF;
        step();
        ex_valid = 1'b0;
        chk("alu_reg_w", 32'(reg_w), 32'd1);
        chk("alu_rd_sel", 32'(rd_sel), 32'd5);
        chk("alu_rd_data", rd_data, 32'hDEAD_BEEF);
        chk("alu_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("alu_fwd_rd", 32'(fwd_rd), 32'd5);
        chk("alu_fwd_data", fwd_data, 32'hDEAD_BEEF);
        step();
        chk("alu_done_reg_w", 32'(reg_w), 32'd0);
        chk("alu_done_busy", 32'(busy), 32'd0);
        chk("idle_keeps_data", rd_data, 32'hDEAD_BEEF);

        // Loads
        do_load("lb2",  3'b000, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF, 1'b0);
        do_load("lb1",  3'b000, 2'd1, 32'h80FF_7F01, 32'h0000_007F, 1'b0);
        do_load("lbu3", 3'b100, 2'd3, 32'h80FF_7F01, 32'h0000_0080, 1'b0);
        do_load("lh2",  3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b0);
        do_load("lhu0", 3'b101, 2'd0, 32'h80FF_7F01, 32'h0000_7F01, 1'b0);
        do_load("lw",   3'b010, 2'd0, 32'h80FF_7F01, 32'h80FF_7F01, 1'b0);
        do_load("lw1",  3'b010, 2'd1, 32'h80FF_7F01, 32'h0, 1'b1);
        do_load("lh1",  3'b001, 2'd1, 32'h80FF_7F01, 32'h0, 1'b1);
        do_load("f011", 3'b011, 2'd0, 32'h80FF_7F01, 32'h0, 1'b1);

        // Write to x0
        ex_valid = 1'b1; ex_rd = 5'd0; ex_result = 32'h1111_2222;
        step();
        ex_valid = 1'b0;
        chk("x0_reg_w", 32'(reg_w), 32'd0);
        chk("x0_fwd", 32'(fwd_valid), 32'd0);
        chk("x0_busy", 32'(busy), 32'd1);
        step();
        chk("x0_idle", 32'(busy), 32'd0);

        // Back-to-back ALU results
        ex_valid = 1'b1; ex_rd = 5'd3; ex_result = 32'h0000_00A3;
        step();
        chk("b2b_first_w", 32'(reg_w), 32'd1);
        chk("b2b_first_data", rd_data, 32'h0000_00A3);
        chk("b2b_ready", 32'(ex_ready), 32'd1);
        ex_rd = 5'd4; ex_result = 32'h0000_00B4;
        step();
        ex_valid = 1'b0;
        chk("b2b_second_w", 32'(reg_w), 32'd1);
        chk("b2b_second_sel", 32'(rd_sel), 32'd4);
        chk("b2b_second_data", rd_data, 32'h0000_00B4);
        step();

        // Bank stall during COMMIT
        ex_valid = 1'b1; ex_rd = 5'd9; ex_result = 32'h1234_5678;
        step();
        ex_valid = 1'b0;
        bank_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("stall_reg_w", 32'(reg_w), 32'd0);
            chk("stall_ex_ready", 32'(ex_ready), 32'd0);
            step();
        end
        chk("stall_fwd", 32'(fwd_valid), 32'd1);
        bank_ready = 1'b1;
        #1;
        chk("stall_release_w", 32'(reg_w), 32'd1);
        chk("stall_release_data", rd_data, 32'h1234_5678);
        step();
        chk("stall_once", 32'(reg_w), 32'd0);
        chk("stall_idle", 32'(busy), 32'd0);

        // Reset during LOAD_WAIT
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd6;
        ex_funct3 = 3'b010; ex_addr_lo = 2'd0;
        step();
        ex_valid = 1'b0; ex_is_load = 1'b0;
        chk("rstld_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstld_ex_ready", 32'(ex_ready), 32'd0);
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        chk("rstld_reg_w", 32'(reg_w), 32'd0);
        chk("rstld_idle", 32'(busy), 32'd0);
        chk("rstld_rd_data", rd_data, 32'd0);
        step();
        chk("rstld_still_idle", 32'(reg_w), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
